// File: rtl/axi_pc_pkg.sv
// axi_pc_pkg: shared FSM state types and AXI4 request constants for the lite-to-AXI4 protocol converter.
package axi_pc_pkg;
   typedef enum logic [2:0] {W_IDLE, W_AW, W_W, W_B, W_RESP} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_AR, R_R, R_RESP} rd_state_e;
   localparam logic [1:0] BURST_INCR = 2'b01;
   function automatic logic [2:0] axi_size(input int unsigned data_width);
      return 3'($clog2(data_width / 8));
   endfunction
endpackage

// File: rtl/axi_lite_to_axi_pc_wr.sv
// axi_lite_to_axi_pc_wr: write path, collects lite AW and W in any order, then issues one AXI4 AW/W/B sequence.
module axi_lite_to_axi_pc_wr
   import axi_pc_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64
) (
   input  logic                        Clk_CI,
   input  logic                        Rst_RBI,
   input  logic [AXI_ADDR_WIDTH-1:0]   lite_aw_addr,
   input  logic                        lite_aw_valid,
   output logic                        lite_aw_ready,
   input  logic [AXI_DATA_WIDTH-1:0]   lite_w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] lite_w_strb,
   input  logic                        lite_w_valid,
   output logic                        lite_w_ready,
   output logic [1:0]                  lite_b_resp,
   output logic                        lite_b_valid,
   input  logic                        lite_b_ready,
   output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
   output logic                        axi_aw_valid,
   input  logic                        axi_aw_ready,
   output logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
   output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
   output logic                        axi_w_valid,
   input  logic                        axi_w_ready,
   input  logic [1:0]                  axi_b_resp,
   input  logic                        axi_b_valid,
   output logic                        axi_b_ready
);
   wr_state_e                   state_q, state_d;
   logic                        aw_have_q, w_have_q, aw_fire, w_fire, go;
   logic [AXI_ADDR_WIDTH-1:0]   addr_q;
   logic [AXI_DATA_WIDTH-1:0]   data_q;
   logic [AXI_DATA_WIDTH/8-1:0] strb_q;
   logic [1:0]                  resp_q;
   assign lite_aw_ready = state_q == W_IDLE && !aw_have_q;
   assign lite_w_ready  = state_q == W_IDLE && !w_have_q;
   assign aw_fire       = lite_aw_valid && lite_aw_ready;
   assign w_fire        = lite_w_valid && lite_w_ready;
   // Leave idle on the edge where the second half arrives, not a cycle later.
   assign go            = state_q == W_IDLE && (aw_have_q || aw_fire) && (w_have_q || w_fire);
   always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
         state_q   <= W_IDLE;
         aw_have_q <= 1'b0;
         w_have_q  <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         resp_q    <= '0;
      end else begin
         state_q   <= state_d;
         aw_have_q <= go ? 1'b0 : aw_have_q || aw_fire;
         w_have_q  <= go ? 1'b0 : w_have_q || w_fire;
         if (aw_fire) addr_q <= lite_aw_addr;
         if (w_fire) begin
            data_q <= lite_w_data;
            strb_q <= lite_w_strb;
         end
         if (state_q == W_B && axi_b_valid) resp_q <= axi_b_resp;
      end
   end
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         W_IDLE:  if (go) state_d = W_AW;
         W_AW:    if (axi_aw_ready) state_d = W_W;
         W_W:     if (axi_w_ready) state_d = W_B;
         W_B:     if (axi_b_valid) state_d = W_RESP;
         W_RESP:  if (lite_b_ready) state_d = W_IDLE;
         default: state_d = W_IDLE;
      endcase
   end
   assign axi_aw_valid = state_q == W_AW;
   assign axi_w_valid  = state_q == W_W;
   assign axi_b_ready  = state_q == W_B;
   assign lite_b_valid = state_q == W_RESP;
   assign axi_aw_addr  = addr_q;
   assign axi_w_data   = data_q;
   assign axi_w_strb   = strb_q;
   assign lite_b_resp  = resp_q;
endmodule

// File: rtl/axi_lite_to_axi_pc.sv
// axi_lite_to_axi_pc: AXI4-Lite responder to AXI4 initiator converter, one outstanding read and one outstanding write.
module axi_lite_to_axi_pc
   import axi_pc_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 10,
   parameter int AXI_ID_VALUE   = 0
) (
   input  logic                        Clk_CI,
   input  logic                        Rst_RBI,
   input  logic [AXI_ADDR_WIDTH-1:0]   lite_aw_addr,
   input  logic                        lite_aw_valid,
   output logic                        lite_aw_ready,
   input  logic [AXI_DATA_WIDTH-1:0]   lite_w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] lite_w_strb,
   input  logic                        lite_w_valid,
   output logic                        lite_w_ready,
   output logic [1:0]                  lite_b_resp,
   output logic                        lite_b_valid,
   input  logic                        lite_b_ready,
   input  logic [AXI_ADDR_WIDTH-1:0]   lite_ar_addr,
   input  logic                        lite_ar_valid,
   output logic                        lite_ar_ready,
   output logic [AXI_DATA_WIDTH-1:0]   lite_r_data,
   output logic [1:0]                  lite_r_resp,
   output logic                        lite_r_valid,
   input  logic                        lite_r_ready,
   output logic [AXI_ID_WIDTH-1:0]     axi_aw_id,
   output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
   output logic [7:0]                  axi_aw_len,
   output logic [2:0]                  axi_aw_size,
   output logic [1:0]                  axi_aw_burst,
   output logic                        axi_aw_lock,
   output logic [3:0]                  axi_aw_cache,
   output logic [2:0]                  axi_aw_prot,
   output logic [3:0]                  axi_aw_qos,
   output logic [3:0]                  axi_aw_region,
   output logic [5:0]                  axi_aw_atop,
   output logic                        axi_aw_user,
   output logic                        axi_aw_valid,
   input  logic                        axi_aw_ready,
   output logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
   output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
   output logic                        axi_w_last,
   output logic                        axi_w_user,
   output logic                        axi_w_valid,
   input  logic                        axi_w_ready,
   input  logic [AXI_ID_WIDTH-1:0]     axi_b_id,
   input  logic [1:0]                  axi_b_resp,
   input  logic                        axi_b_valid,
   output logic                        axi_b_ready,
   output logic [AXI_ID_WIDTH-1:0]     axi_ar_id,
   output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr,
   output logic [7:0]                  axi_ar_len,
   output logic [2:0]                  axi_ar_size,
   output logic [1:0]                  axi_ar_burst,
   output logic                        axi_ar_lock,
   output logic [3:0]                  axi_ar_cache,
   output logic [2:0]                  axi_ar_prot,
   output logic [3:0]                  axi_ar_qos,
   output logic [3:0]                  axi_ar_region,
   output logic                        axi_ar_user,
   output logic                        axi_ar_valid,
   input  logic                        axi_ar_ready,
   input  logic [AXI_ID_WIDTH-1:0]     axi_r_id,
   input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data,
   input  logic [1:0]                  axi_r_resp,
   input  logic                        axi_r_last,
   input  logic                        axi_r_valid,
   output logic                        axi_r_ready
);
   localparam logic [2:0] SIZE = axi_size(AXI_DATA_WIDTH);
   localparam logic [AXI_ID_WIDTH-1:0] ID = AXI_ID_WIDTH'(AXI_ID_VALUE);
   rd_state_e                 rd_state_q, rd_state_d;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
   logic [AXI_DATA_WIDTH-1:0] r_data_q;
   logic [1:0]                r_resp_q;
   logic                      unused_inputs;
   // Single-beat transfers with a fixed ID make these fields irrelevant.
   assign unused_inputs = ^{axi_b_id, axi_r_id, axi_r_last};
   assign {axi_aw_id, axi_aw_len, axi_aw_size, axi_aw_burst} = {ID, 8'd0, SIZE, BURST_INCR};
   assign {axi_aw_lock, axi_aw_cache, axi_aw_prot, axi_aw_qos, axi_aw_region, axi_aw_atop, axi_aw_user} = '0;
   assign {axi_ar_id, axi_ar_len, axi_ar_size, axi_ar_burst} = {ID, 8'd0, SIZE, BURST_INCR};
   assign {axi_ar_lock, axi_ar_cache, axi_ar_prot, axi_ar_qos, axi_ar_region, axi_ar_user} = '0;
   assign axi_w_last = 1'b1;
   assign axi_w_user = 1'b0;
   axi_lite_to_axi_pc_wr #(
      .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
      .AXI_DATA_WIDTH(AXI_DATA_WIDTH)
   ) i_wr (
      .Clk_CI        (Clk_CI),
      .Rst_RBI       (Rst_RBI),
      .lite_aw_addr  (lite_aw_addr),
      .lite_aw_valid (lite_aw_valid),
      .lite_aw_ready (lite_aw_ready),
      .lite_w_data   (lite_w_data),
      .lite_w_strb   (lite_w_strb),
      .lite_w_valid  (lite_w_valid),
      .lite_w_ready  (lite_w_ready),
      .lite_b_resp   (lite_b_resp),
      .lite_b_valid  (lite_b_valid),
      .lite_b_ready  (lite_b_ready),
      .axi_aw_addr   (axi_aw_addr),
      .axi_aw_valid  (axi_aw_valid),
      .axi_aw_ready  (axi_aw_ready),
      .axi_w_data    (axi_w_data),
      .axi_w_strb    (axi_w_strb),
      .axi_w_valid   (axi_w_valid),
      .axi_w_ready   (axi_w_ready),
      .axi_b_resp    (axi_b_resp),
      .axi_b_valid   (axi_b_valid),
      .axi_b_ready   (axi_b_ready)
   );
   always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
         rd_state_q <= R_IDLE;
         ar_addr_q  <= '0;
         r_data_q   <= '0;
         r_resp_q   <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         if (rd_state_q == R_IDLE && lite_ar_valid) ar_addr_q <= lite_ar_addr;
         if (rd_state_q == R_R && axi_r_valid) begin
            r_data_q <= axi_r_data;
            r_resp_q <= axi_r_resp;
         end
      end
   end
   always_comb begin
      rd_state_d = rd_state_q;
      unique case (rd_state_q)
         R_IDLE:  if (lite_ar_valid) rd_state_d = R_AR;
         R_AR:    if (axi_ar_ready) rd_state_d = R_R;
         R_R:     if (axi_r_valid) rd_state_d = R_RESP;
         R_RESP:  if (lite_r_ready) rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase
   end
   assign lite_ar_ready = rd_state_q == R_IDLE;
   assign axi_ar_valid  = rd_state_q == R_AR;
   assign axi_r_ready   = rd_state_q == R_R;
   assign lite_r_valid  = rd_state_q == R_RESP;
   assign axi_ar_addr   = ar_addr_q;
   assign lite_r_data   = r_data_q;
   assign lite_r_resp   = r_resp_q;
endmodule

// File: tb/tb_axi_lite_to_axi_pc.sv
// tb_axi_lite_to_axi_pc: scoreboard bench with a reactive AXI4 responder, vector table and corner-case sequences.
module tb_axi_lite_to_axi_pc;
   logic        Clk_CI, Rst_RBI;
   logic [31:0] lite_aw_addr, lite_ar_addr, axi_aw_addr, axi_ar_addr;
   logic        lite_aw_valid, lite_aw_ready, lite_w_valid, lite_w_ready, lite_b_valid, lite_b_ready;
   logic        lite_ar_valid, lite_ar_ready, lite_r_valid, lite_r_ready;
   logic [63:0] lite_w_data, lite_r_data, axi_w_data, axi_r_data;
   logic [7:0]  lite_w_strb, axi_w_strb, axi_aw_len, axi_ar_len;
   logic [1:0]  lite_b_resp, lite_r_resp, axi_b_resp, axi_r_resp, axi_aw_burst, axi_ar_burst;
   logic [9:0]  axi_aw_id, axi_ar_id, axi_b_id, axi_r_id;
   logic [2:0]  axi_aw_size, axi_ar_size, axi_aw_prot, axi_ar_prot;
   logic [3:0]  axi_aw_cache, axi_ar_cache, axi_aw_qos, axi_ar_qos, axi_aw_region, axi_ar_region;
   logic [5:0]  axi_aw_atop;
   logic        axi_aw_lock, axi_ar_lock, axi_aw_user, axi_ar_user, axi_w_user, axi_w_last;
   logic        axi_aw_valid, axi_aw_ready, axi_w_valid, axi_w_ready, axi_b_valid, axi_b_ready;
   logic        axi_ar_valid, axi_ar_ready, axi_r_last, axi_r_valid, axi_r_ready;
   logic [1:0]  slv_bresp, slv_rresp;
   logic [63:0] slv_rdata;
   logic        s_rst, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;
   int          tests = 0, fails = 0;
   logic [31:0] aw_q[$], ar_q[$];
   logic [71:0] w_q[$];
   logic [1:0]  b_q[$];
   logic [65:0] r_q[$];
   localparam logic [1:0] OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11;
   typedef struct {
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [7:0]  strb;
      logic [1:0]  bresp;
      logic [63:0] rdata;
      logic [1:0]  rresp;
   } vec_t;
   vec_t vecs[4];

   axi_lite_to_axi_pc #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_ID_VALUE(0)) dut (
      .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
      .lite_aw_addr(lite_aw_addr), .lite_aw_valid(lite_aw_valid), .lite_aw_ready(lite_aw_ready),
      .lite_w_data(lite_w_data), .lite_w_strb(lite_w_strb), .lite_w_valid(lite_w_valid), .lite_w_ready(lite_w_ready),
      .lite_b_resp(lite_b_resp), .lite_b_valid(lite_b_valid), .lite_b_ready(lite_b_ready),
      .lite_ar_addr(lite_ar_addr), .lite_ar_valid(lite_ar_valid), .lite_ar_ready(lite_ar_ready),
      .lite_r_data(lite_r_data), .lite_r_resp(lite_r_resp), .lite_r_valid(lite_r_valid), .lite_r_ready(lite_r_ready),
      .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len), .axi_aw_size(axi_aw_size),
      .axi_aw_burst(axi_aw_burst), .axi_aw_lock(axi_aw_lock), .axi_aw_cache(axi_aw_cache), .axi_aw_prot(axi_aw_prot),
      .axi_aw_qos(axi_aw_qos), .axi_aw_region(axi_aw_region), .axi_aw_atop(axi_aw_atop), .axi_aw_user(axi_aw_user),
      .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
      .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last), .axi_w_user(axi_w_user),
      .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
      .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
      .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
      .axi_ar_burst(axi_ar_burst), .axi_ar_lock(axi_ar_lock), .axi_ar_cache(axi_ar_cache), .axi_ar_prot(axi_ar_prot),
      .axi_ar_qos(axi_ar_qos), .axi_ar_region(axi_ar_region), .axi_ar_user(axi_ar_user),
      .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
      .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last),
      .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready)
   );

   initial begin
      Clk_CI = 1'b0;
      forever #5 Clk_CI = !Clk_CI;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic no_exp(input string name);
      tests++;
      fails++;
      $display("FAIL %s: handshake with no expected entry at %0t", name, $time);
   endtask

   // AXI4 responder: B one cycle after a W handshake, R one cycle after an AR handshake.
   initial begin
      {axi_b_valid, axi_r_valid, axi_b_resp, axi_r_resp, axi_r_data, axi_r_last} = '0;
      axi_b_id = 10'h7;
      axi_r_id = 10'h7;
      forever begin
         @(negedge Clk_CI);
         s_rst   = Rst_RBI;
         s_w_hs  = axi_w_valid && axi_w_ready;
         s_b_hs  = axi_b_valid && axi_b_ready;
         s_ar_hs = axi_ar_valid && axi_ar_ready;
         s_r_hs  = axi_r_valid && axi_r_ready;
         @(posedge Clk_CI);
         #1;
         if (!s_rst) begin
            axi_b_valid = 1'b0;
            axi_r_valid = 1'b0;
         end else begin
            if (s_b_hs) axi_b_valid = 1'b0;
            if (s_w_hs) begin
               axi_b_valid = 1'b1;
               axi_b_resp  = slv_bresp;
            end
            if (s_r_hs) axi_r_valid = 1'b0;
            if (s_ar_hs) begin
               axi_r_valid = 1'b1;
               axi_r_data  = slv_rdata;
               axi_r_resp  = slv_rresp;
            end
         end
      end
   end

   // Scoreboard: every handshake pops and compares against what the stimulus pushed.
   initial forever begin
      @(negedge Clk_CI);
      if (axi_aw_valid && axi_aw_ready) begin
         if (aw_q.size() == 0) no_exp("axi_aw");
         else chk("axi_aw_addr", axi_aw_addr, aw_q.pop_front());
         chk("axi_aw_const", {axi_aw_len, axi_aw_size, axi_aw_burst, axi_aw_id, axi_aw_lock, axi_aw_cache,
             axi_aw_prot, axi_aw_qos, axi_aw_region, axi_aw_atop, axi_aw_user}, {8'd0, 3'd3, 2'b01, 33'd0});
      end
      if (axi_w_valid && axi_w_ready) begin
         if (w_q.size() == 0) no_exp("axi_w");
         else chk("axi_w_strb_data", {axi_w_strb, axi_w_data}, w_q.pop_front());
         chk("axi_w_last_user", {axi_w_last, axi_w_user}, 2'b10);
      end
      if (axi_ar_valid && axi_ar_ready) begin
         if (ar_q.size() == 0) no_exp("axi_ar");
         else chk("axi_ar_addr", axi_ar_addr, ar_q.pop_front());
         chk("axi_ar_const", {axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_id, axi_ar_lock, axi_ar_cache,
             axi_ar_prot, axi_ar_qos, axi_ar_region, axi_ar_user}, {8'd0, 3'd3, 2'b01, 27'd0});
      end
      if (lite_b_valid && lite_b_ready) begin
         if (b_q.size() == 0) no_exp("lite_b");
         else chk("lite_b_resp", lite_b_resp, b_q.pop_front());
      end
      if (lite_r_valid && lite_r_ready) begin
         if (r_q.size() == 0) no_exp("lite_r");
         else chk("lite_r_resp_data", {lite_r_resp, lite_r_data}, r_q.pop_front());
      end
   end

   task automatic step();
      @(posedge Clk_CI);
      #1;
   endtask

   task automatic lite_aw(input logic [31:0] a);
      lite_aw_addr  = a;
      lite_aw_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge Clk_CI);
         if (lite_aw_ready) begin
            step();
            lite_aw_valid = 1'b0;
            return;
         end
         step();
      end
      lite_aw_valid = 1'b0;
      no_exp("lite_aw_timeout");
   endtask

   task automatic lite_w(input logic [63:0] d, input logic [7:0] s);
      lite_w_data  = d;
      lite_w_strb  = s;
      lite_w_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge Clk_CI);
         if (lite_w_ready) begin
            step();
            lite_w_valid = 1'b0;
            return;
         end
         step();
      end
      lite_w_valid = 1'b0;
      no_exp("lite_w_timeout");
   endtask

   task automatic lite_ar(input logic [31:0] a);
      lite_ar_addr  = a;
      lite_ar_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge Clk_CI);
         if (lite_ar_ready) begin
            step();
            lite_ar_valid = 1'b0;
            return;
         end
         step();
      end
      lite_ar_valid = 1'b0;
      no_exp("lite_ar_timeout");
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         step();
         if (aw_q.size() + w_q.size() + b_q.size() + ar_q.size() + r_q.size() == 0) return;
      end
      no_exp("drain_timeout");
   endtask

   initial begin
      vecs[0] = '{32'h0000_1000, 64'h0123_4567_89AB_CDEF, 8'hFF, OKAY,   64'h1111_2222_3333_4444, OKAY};
      vecs[1] = '{32'h0000_2008, 64'hFFFF_0000_FFFF_0000, 8'h0F, EXOKAY, 64'hA5A5_A5A5_5A5A_5A5A, SLVERR};
      vecs[2] = '{32'hFFFF_FFF8, 64'h0000_0000_0000_0001, 8'hA5, SLVERR, 64'hFFFF_FFFF_FFFF_FFFF, DECERR};
      vecs[3] = '{32'h8000_0010, 64'h8000_0000_0000_0000, 8'h80, DECERR, 64'h0,                   EXOKAY};
      Rst_RBI = 1'b0;
      {lite_aw_valid, lite_w_valid, lite_ar_valid} = '0;
      {lite_aw_addr, lite_ar_addr, lite_w_data, lite_w_strb} = '0;
      {lite_b_ready, lite_r_ready, axi_aw_ready, axi_w_ready, axi_ar_ready} = '1;
      slv_bresp = OKAY;
      slv_rresp = OKAY;
      slv_rdata = '0;
      repeat (3) step();
      @(negedge Clk_CI);
      chk("reset_valids", {axi_aw_valid, axi_w_valid, axi_b_ready, axi_ar_valid, axi_r_ready, lite_b_valid, lite_r_valid}, 7'd0);
      step();
      Rst_RBI = 1'b1;
      step();
      @(negedge Clk_CI);
      chk("post_reset_readies", {lite_aw_ready, lite_w_ready, lite_ar_ready}, 3'b111);
      step();

      // Same-cycle lite AW+W: axi AW in cycle 1, W in cycle 2, B in cycle 3, lite B in cycle 4.
      aw_q.push_back(32'h100);
      w_q.push_back({8'hFF, 64'hDEAD_BEEF_CAFE_F00D});
      b_q.push_back(OKAY);
      fork
         lite_aw(32'h100);
         lite_w(64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
      join
      @(negedge Clk_CI);
      chk("lat_c1_aw", {axi_aw_valid, axi_w_valid}, 2'b10);
      @(negedge Clk_CI);
      chk("lat_c2_w", {axi_aw_valid, axi_w_valid, axi_w_last}, 3'b011);
      @(negedge Clk_CI);
      chk("lat_c3_b", {axi_b_ready, axi_b_valid, lite_b_valid}, 3'b110);
      @(negedge Clk_CI);
      chk("lat_c4_lite_b", {lite_b_valid, lite_b_resp}, {1'b1, OKAY});
      wait_idle();

      // W three cycles ahead of AW: no axi AW and no second W accept until the AW arrives.
      aw_q.push_back(32'h40);
      w_q.push_back({8'h3C, 64'h5555_6666_7777_8888});
      b_q.push_back(OKAY);
      lite_w(64'h5555_6666_7777_8888, 8'h3C);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk_CI);
         chk("w_first_hold", {lite_w_ready, lite_aw_ready, axi_aw_valid}, 3'b010);
         step();
      end
      lite_aw(32'h40);
      @(negedge Clk_CI);
      chk("w_first_ready_low", {lite_w_ready, axi_aw_valid}, 2'b01);
      wait_idle();

      // Stalled axi aw_ready with SLVERR response.
      axi_aw_ready = 1'b0;
      slv_bresp    = SLVERR;
      aw_q.push_back(32'h0000_0C00);
      w_q.push_back({8'h01, 64'h42});
      b_q.push_back(SLVERR);
      fork
         lite_aw(32'h0000_0C00);
         lite_w(64'h42, 8'h01);
      join
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk_CI);
         chk("aw_stall_hold", {axi_aw_valid, axi_aw_addr, axi_w_valid}, {1'b1, 32'h0000_0C00, 1'b0});
         step();
      end
      axi_aw_ready = 1'b1;
      wait_idle();
      slv_bresp = OKAY;

      // Read with lite r_ready held low: r_valid and data held, no new AR accepted.
      lite_r_ready = 1'b0;
      slv_rdata    = 64'h1234;
      ar_q.push_back(32'h200);
      r_q.push_back({OKAY, 64'h1234});
      lite_ar(32'h200);
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk_CI);
         chk("r_stall_ar_ready", lite_ar_ready, 1'b0);
         if (i >= 2) chk("r_stall_hold", {lite_r_valid, lite_r_data}, {1'b1, 64'h1234});
         step();
      end
      lite_r_ready = 1'b1;
      wait_idle();

      // Concurrent read and write.
      slv_rdata = 64'h0BAD_F00D_0000_0300;
      aw_q.push_back(32'h308);
      w_q.push_back({8'hF0, 64'h3080_3080_3080_3080});
      b_q.push_back(OKAY);
      ar_q.push_back(32'h300);
      r_q.push_back({OKAY, 64'h0BAD_F00D_0000_0300});
      fork
         lite_aw(32'h308);
         lite_w(64'h3080_3080_3080_3080, 8'hF0);
         lite_ar(32'h300);
      join
      wait_idle();

      // Vector table: write and read per entry, issued together.
      for (int v = 0; v < 4; v++) begin
         slv_bresp = vecs[v].bresp;
         slv_rdata = vecs[v].rdata;
         slv_rresp = vecs[v].rresp;
         aw_q.push_back(vecs[v].addr);
         w_q.push_back({vecs[v].strb, vecs[v].wdata});
         b_q.push_back(vecs[v].bresp);
         ar_q.push_back(vecs[v].addr ^ 32'h8);
         r_q.push_back({vecs[v].rresp, vecs[v].rdata});
         fork
            lite_aw(vecs[v].addr);
            lite_w(vecs[v].wdata, vecs[v].strb);
            lite_ar(vecs[v].addr ^ 32'h8);
         join
         wait_idle();
      end
      slv_bresp = OKAY;
      slv_rresp = OKAY;

      // Reset while waiting in W_W: transaction abandoned, no late B.
      axi_w_ready = 1'b0;
      aw_q.push_back(32'h500);
      fork
         lite_aw(32'h500);
         lite_w(64'h5005, 8'hFF);
      join
      @(negedge Clk_CI);
      @(negedge Clk_CI);
      chk("rst_in_ww", axi_w_valid, 1'b1);
      step();
      Rst_RBI = 1'b0;
      step();
      @(negedge Clk_CI);
      chk("rst_valids", {axi_aw_valid, axi_w_valid, axi_b_ready, lite_b_valid}, 4'd0);
      step();
      Rst_RBI = 1'b1;
      step();
      @(negedge Clk_CI);
      chk("rst_release_readies", {lite_aw_ready, lite_w_ready, lite_ar_ready}, 3'b111);
      axi_w_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk_CI);
         chk("rst_no_stale", {axi_aw_valid, axi_w_valid, axi_b_valid, lite_b_valid}, 4'd0);
      end
      chk("leftover_expectations", aw_q.size() + w_q.size() + b_q.size() + ar_q.size() + r_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
